perf_counter_bank: RTL and testbench
====================================

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 The block SHALL have parameter CH, default 4, meaning number of event channels (1..15).
REQ-002 The block SHALL have parameter W, default 32, meaning counter width in bits (4..64).
REQ-003 The block SHALL have parameter SAT, default 0, meaning overflow mode: 0 = wrap to zero, 1 = saturate at all-ones.
REQ-004 The block SHALL define derived constant SW = $clog2(CH+1), the select width.
REQ-005 in_CLK  input  1  the single clock; all state SHALL update on the falling edge.
REQ-006 in_RST_N  input  1  reset, asynchronous and active-low.
REQ-007 in_EN  input  1  CPU run enable; low = CPU halted.
REQ-008 in_CLR  input  1  synchronous clear of live counters.
REQ-009 in_FREEZE  input  1  holds all live counters.
REQ-010 in_EVT  input  CH  per-channel event pulses; bit k = channel k.
REQ-011 in_MASK  input  CH  per-channel count enable.
REQ-012 in_SNAP  input  1  copies all live counters into shadow registers.
REQ-013 in_SEL  input  SW  readout select: 0 = total, k = channel k-1.
REQ-014 out_total  output  W  live total-cycle counter.
REQ-015 out_DATA  output  W  registered readout of the selected shadow register.
REQ-016 out_OVF  output  CH+1  sticky overflow flags: bit 0 = total, bit k = channel k-1.
REQ-017 out_halted  output  1  halt-seen flag.

Function
REQ-018 The block SHALL apply the following priority per falling edge: reset > in_CLR > in_FREEZE > counting.
REQ-019 Total counter, in_EN=1: the counter SHALL increment and out_halted SHALL clear.
REQ-020 Total counter, in_EN=0 and out_halted=0: the counter SHALL increment once and out_halted SHALL set.
REQ-021 Total counter, in_EN=0 and out_halted=1: the counter SHALL hold, so a halt contributes exactly one cycle.
REQ-022 Channel k SHALL increment by one on an edge where in_EVT[k] & in_MASK[k] = 1; otherwise it SHALL hold.
REQ-023 Channels and the total counter SHALL update independently on the same edge.
REQ-024 An increment from all-ones with SAT=0 SHALL wrap the counter to 0; with SAT=1 the counter SHALL stay at all-ones.
REQ-025 In either overflow mode, an increment from all-ones SHALL set the matching out_OVF bit.
REQ-026 out_OVF bits SHALL stay set until in_CLR or reset.
REQ-027 in_CLR SHALL zero all live counters, out_OVF and out_halted; shadow registers and out_DATA SHALL be unaffected.
REQ-028 in_FREEZE=1 SHALL hold all live counters, out_OVF and out_halted; in_SNAP and the readout SHALL still operate.
REQ-029 in_SNAP=1 SHALL load every shadow register with its live counter's value held before that edge.
REQ-030 in_SNAP with in_CLR on the same edge SHALL capture the pre-clear values.
REQ-031 out_DATA SHALL load shadow[in_SEL] on each falling edge, giving one edge of latency.
REQ-032 A read selected on the same edge as a snapshot SHALL return the previous shadow contents.
REQ-033 An in_SEL value greater than CH SHALL make out_DATA load 0.
REQ-034 All arithmetic SHALL be unsigned W-bit; no output SHALL change except on a falling edge or on reset.

Reset
REQ-035 Asserting in_RST_N low SHALL immediately clear all live counters, shadow registers, out_DATA, out_OVF and out_halted to 0, independent of in_CLK.
REQ-036 After in_RST_N deasserts, the first counting edge SHALL be the first falling edge with in_RST_N high.
REQ-037 Reset asserted mid-count SHALL discard the in-progress increment.

Verification
REQ-038 Halt collapse (defaults): in_EN=1 for 5 edges, 0 for 4 edges, 1 for 2 edges -> out_total=8; out_halted=1 after edge 6 and 0 after edge 10.
REQ-039 Masking (CH=4): in_EVT=4'b1111 for 3 edges with in_MASK=4'b0101 -> channel0=3, channel1=0, channel2=3, channel3=0.
REQ-040 Wrap vs saturate (W=4): 17 events on channel 0 -> SAT=0 gives 1 with out_OVF[1]=1; SAT=1 gives 15 with out_OVF[1]=1.
REQ-041 Snapshot/readout: channel1=7, pulse in_SNAP with in_CLR, in_SEL=2 -> out_DATA=7 one edge later, live channel1=0, out_OVF=0.
REQ-042 Freeze: in_FREEZE=1 for 5 edges with in_EN=1 and in_EVT all-ones -> all counters unchanged; an in_SNAP during the freeze still captures them.
REQ-043 Async reset: assert in_RST_N between edges with counters nonzero -> all outputs 0 before the next edge; in_SEL=CH+1 afterwards -> out_DATA=0.

Source files
------------

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: total-cycle and per-channel event counters with halt collapse, snapshot shadows and registered readout
// Ports: in_CLK (state updates on falling edge), in_RST_N (async active-low reset),
//        in_EN (CPU run enable), in_CLR (sync clear of live state), in_FREEZE (hold live state),
//        in_EVT/in_MASK (per-channel event pulses and count enables), in_SNAP (copy live to shadow),
//        in_SEL (readout select, 0 = total, k = channel k-1), out_total (live total counter),
//        out_DATA (registered shadow readout), out_OVF (sticky overflow flags), out_halted (halt-seen flag)
module perf_counter_bank #(
  parameter int CH = 4,
  parameter int W = 32,
  parameter int SAT = 0,
  localparam int SW = $clog2(CH + 1)
) (
  input  logic          in_CLK,
  input  logic          in_RST_N,
  input  logic          in_EN,
  input  logic          in_CLR,
  input  logic          in_FREEZE,
  input  logic [CH-1:0] in_EVT,
  input  logic [CH-1:0] in_MASK,
  input  logic          in_SNAP,
  input  logic [SW-1:0] in_SEL,
  output logic [W-1:0]  out_total,
  output logic [W-1:0]  out_DATA,
  output logic [CH:0]   out_OVF,
  output logic          out_halted
);
  logic [W-1:0] total, data, rd;
  logic [W-1:0] cnt [CH];
  logic [W-1:0] shadow [CH+1];
  logic [CH:0]  ovf;
  logic         halted;
  function automatic logic [W-1:0] bump(input logic [W-1:0] v);
    return (&v) ? ((SAT != 0) ? v : '0) : v + W'(1);
  endfunction
  // Selects above CH read as zero.
  always_comb begin
    rd = '0;
    for (int i = 0; i <= CH; i++)
      if (in_SEL == SW'(i)) rd = shadow[i];
  end
  always_ff @(negedge in_CLK or negedge in_RST_N) begin
    if (!in_RST_N) begin
      total  <= '0;
      data   <= '0;
      ovf    <= '0;
      halted <= 1'b0;
      for (int k = 0; k < CH; k++) cnt[k] <= '0;
      for (int k = 0; k <= CH; k++) shadow[k] <= '0;
    end else begin
      // Snapshot and readout see pre-edge values, so they work under clear and freeze alike.
      if (in_SNAP) begin
        shadow[0] <= total;
        for (int k = 0; k < CH; k++) shadow[k+1] <= cnt[k];
      end
      data <= rd;
      if (in_CLR) begin
        total  <= '0;
        ovf    <= '0;
        halted <= 1'b0;
        for (int k = 0; k < CH; k++) cnt[k] <= '0;
      end else if (!in_FREEZE) begin
        // A halt counts its first cycle only; the rest of the halt is collapsed.
        if (in_EN || !halted) begin
          total <= bump(total);
          if (&total) ovf[0] <= 1'b1;
        end
        halted <= !in_EN;
        for (int k = 0; k < CH; k++)
          if (in_EVT[k] && in_MASK[k]) begin
            cnt[k] <= bump(cnt[k]);
            if (&cnt[k]) ovf[k+1] <= 1'b1;
          end
      end
    end
  end
  assign out_total  = total;
  assign out_DATA   = data;
  assign out_OVF    = ovf;
  assign out_halted = halted;
endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: directed and random checks of three counter-bank configurations against a behavioural model
module tb_perf_counter_bank;
  logic clk, rst_n, en, clr, freeze, snap;
  logic [3:0] evt, mask;
  logic [2:0] sel;
  logic [31:0] tot0, data0;
  logic [3:0] tot1, data1, tot2, data2;
  logic [4:0] ovf0, ovf1, ovf2;
  logic h0, h1, h2;
  int checks = 0;
  int errors = 0;
  logic [63:0] mtot [3];
  logic [63:0] mdata [3];
  logic [63:0] movf [3];
  logic [63:0] mch [3][4];
  logic [63:0] mshd [3][5];
  logic mhalt [3];
  logic [63:0] t_hold;
  perf_counter_bank dut0 (.in_CLK(clk), .in_RST_N(rst_n), .in_EN(en), .in_CLR(clr), .in_FREEZE(freeze),
    .in_EVT(evt), .in_MASK(mask), .in_SNAP(snap), .in_SEL(sel),
    .out_total(tot0), .out_DATA(data0), .out_OVF(ovf0), .out_halted(h0));
  perf_counter_bank #(.W(4), .SAT(0)) dut1 (.in_CLK(clk), .in_RST_N(rst_n), .in_EN(en), .in_CLR(clr), .in_FREEZE(freeze),
    .in_EVT(evt), .in_MASK(mask), .in_SNAP(snap), .in_SEL(sel),
    .out_total(tot1), .out_DATA(data1), .out_OVF(ovf1), .out_halted(h1));
  perf_counter_bank #(.W(4), .SAT(1)) dut2 (.in_CLK(clk), .in_RST_N(rst_n), .in_EN(en), .in_CLR(clr), .in_FREEZE(freeze),
    .in_EVT(evt), .in_MASK(mask), .in_SNAP(snap), .in_SEL(sel),
    .out_total(tot2), .out_DATA(data2), .out_OVF(ovf2), .out_halted(h2));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [63:0] wmax(input int d);
    return (d == 0) ? 64'hFFFF_FFFF : 64'hF;
  endfunction
  function automatic logic [63:0] inc(input logic [63:0] v, input int d);
    return (v == wmax(d)) ? ((d == 2) ? v : 64'd0) : v + 64'd1;
  endfunction
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask
  task automatic mreset();
    for (int d = 0; d < 3; d++) begin
      mtot[d] = 0; mdata[d] = 0; movf[d] = 0; mhalt[d] = 1'b0;
      for (int k = 0; k < 4; k++) mch[d][k] = 0;
      for (int k = 0; k < 5; k++) mshd[d][k] = 0;
    end
  endtask
  task automatic model_edge();
    for (int d = 0; d < 3; d++) begin
      logic [63:0] nd;
      nd = (sel <= 3'd4) ? mshd[d][sel] : 64'd0;
      if (snap) begin
        mshd[d][0] = mtot[d];
        for (int k = 0; k < 4; k++) mshd[d][k+1] = mch[d][k];
      end
      mdata[d] = nd;
      if (clr) begin
        mtot[d] = 0; movf[d] = 0; mhalt[d] = 1'b0;
        for (int k = 0; k < 4; k++) mch[d][k] = 0;
      end else if (!freeze) begin
        if (en || !mhalt[d]) begin
          if (mtot[d] == wmax(d)) movf[d][0] = 1'b1;
          mtot[d] = inc(mtot[d], d);
        end
        mhalt[d] = !en;
        for (int k = 0; k < 4; k++)
          if (evt[k] && mask[k]) begin
            if (mch[d][k] == wmax(d)) movf[d][k+1] = 1'b1;
            mch[d][k] = inc(mch[d][k], d);
          end
      end
    end
  endtask
  task automatic cmp_all();
    check("d0_total", 64'(tot0), mtot[0]);
    check("d0_data", 64'(data0), mdata[0]);
    check("d0_ovf", 64'(ovf0), movf[0]);
    check("d0_halted", 64'(h0), 64'(mhalt[0]));
    check("d1_total", 64'(tot1), mtot[1]);
    check("d1_data", 64'(data1), mdata[1]);
    check("d1_ovf", 64'(ovf1), movf[1]);
    check("d1_halted", 64'(h1), 64'(mhalt[1]));
    check("d2_total", 64'(tot2), mtot[2]);
    check("d2_data", 64'(data2), mdata[2]);
    check("d2_ovf", 64'(ovf2), movf[2]);
    check("d2_halted", 64'(h2), 64'(mhalt[2]));
  endtask
  task automatic step();
    @(negedge clk);
    model_edge();
    @(posedge clk);
    cmp_all();
  endtask
  task automatic all_zero(input string tag);
    check({tag, "_t0"}, 64'(tot0), 64'd0);
    check({tag, "_d0"}, 64'(data0), 64'd0);
    check({tag, "_o0"}, 64'(ovf0), 64'd0);
    check({tag, "_h0"}, 64'(h0), 64'd0);
    check({tag, "_t1"}, 64'(tot1), 64'd0);
    check({tag, "_d1"}, 64'(data1), 64'd0);
    check({tag, "_o1"}, 64'(ovf1), 64'd0);
    check({tag, "_t2"}, 64'(tot2), 64'd0);
    check({tag, "_d2"}, 64'(data2), 64'd0);
    check({tag, "_o2"}, 64'(ovf2), 64'd0);
  endtask
  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; freeze = 1'b0; snap = 1'b0;
    evt = 4'h0; mask = 4'h0; sel = 3'd0;
    mreset();
    repeat (2) @(posedge clk);
    all_zero("reset");
    rst_n = 1'b1;
    en = 1'b1; repeat (5) step();
    en = 1'b0; step(); check("halt_set", 64'(h0), 64'd1);
    repeat (3) step();
    en = 1'b1; step(); check("halt_clr", 64'(h0), 64'd0);
    step(); check("halt_total", 64'(tot0), 64'd8);
    clr = 1'b1; step(); clr = 1'b0;
    evt = 4'hF; mask = 4'h5; repeat (3) step();
    evt = 4'h0; snap = 1'b1; step(); snap = 1'b0;
    sel = 3'd1; step(); check("mask_ch0", 64'(data0), 64'd3);
    sel = 3'd2; step(); check("mask_ch1", 64'(data0), 64'd0);
    sel = 3'd3; step(); check("mask_ch2", 64'(data0), 64'd3);
    sel = 3'd4; step(); check("mask_ch3", 64'(data0), 64'd0);
    clr = 1'b1; step(); clr = 1'b0;
    evt = 4'h1; mask = 4'h1; repeat (17) step();
    evt = 4'h0; snap = 1'b1; step(); snap = 1'b0;
    sel = 3'd1; step();
    check("wrap_ch0", 64'(data1), 64'd1);
    check("wrap_ovf", 64'(ovf1[1]), 64'd1);
    check("sat_ch0", 64'(data2), 64'd15);
    check("sat_ovf", 64'(ovf2[1]), 64'd1);
    clr = 1'b1; step(); clr = 1'b0;
    evt = 4'h2; mask = 4'h2; repeat (7) step();
    evt = 4'h0; snap = 1'b1; clr = 1'b1; sel = 3'd2; step();
    check("sc_ovf", 64'(ovf0), 64'd0);
    check("sc_total", 64'(tot0), 64'd0);
    snap = 1'b0; clr = 1'b0; step(); check("sc_data", 64'(data0), 64'd7);
    snap = 1'b1; step(); check("sc_prev", 64'(data0), 64'd7);
    snap = 1'b0; step(); check("sc_live_ch1", 64'(data0), 64'd0);
    evt = 4'hF; mask = 4'hF; repeat (2) step();
    t_hold = mtot[0];
    freeze = 1'b1;
    for (int i = 0; i < 5; i++) begin
      snap = (i == 2);
      step();
      check("frz_total", 64'(tot0), t_hold);
    end
    freeze = 1'b0; snap = 1'b0; evt = 4'h0; sel = 3'd1; step();
    check("frz_snap_ch0", 64'(data0), 64'd2);
    sel = 3'd0; step(); check("frz_snap_total", 64'(data0), t_hold);
    repeat (300) begin
      en = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 31) == 0);
      freeze = ($urandom_range(0, 15) == 0);
      snap = ($urandom_range(0, 3) == 0);
      evt = 4'($urandom);
      mask = 4'($urandom);
      sel = 3'($urandom);
      step();
    end
    clr = 1'b0; freeze = 1'b0; snap = 1'b0; en = 1'b1; evt = 4'hF; mask = 4'hF;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1 all_zero("async");
    mreset();
    evt = 4'h0; sel = 3'd5;
    @(negedge clk);
    @(posedge clk);
    rst_n = 1'b1;
    step();
    check("rst_first_total", 64'(tot0), 64'd1);
    check("rst_sel_oob", 64'(data0), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
